// File: rtl/pwm_dir_multi.sv
// pwm_dir_multi: NUM_CH PWM/direction channels on one shared period counter, with
// boundary-applied shadow settings and dead-time on reversal. Option macro: PWM_CENTER_ALIGNED_EN.
module pwm_dir_multi #(
  parameter int NUM_CH          = 2,
  parameter int CLK_FREQUENCY   = 60_000_000,
  parameter int PWM_FREQUENCY   = 100_000,
  parameter int DUTY_BITS       = 7,
  parameter int DUTY_MAX        = 100,
  parameter int DEADTIME_CYCLES = 60
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          update,
  input  logic [NUM_CH*DUTY_BITS-1:0]   duty,
  input  logic [NUM_CH-1:0]             dir_in,
  input  logic [NUM_CH-1:0]             float,
  output logic [NUM_CH-1:0]             pwm,
  output logic [NUM_CH-1:0]             dir_out,
  output logic [NUM_CH-1:0]             float_n,
  output logic                          period_start
);

  localparam int PERIOD_COUNT = CLK_FREQUENCY / PWM_FREQUENCY;
  localparam int DUTY_STEP    = PERIOD_COUNT / DUTY_MAX;
  localparam int CW           = $clog2(PERIOD_COUNT);
  localparam int TW           = $clog2(PERIOD_COUNT + 1);
  localparam int DW           = $clog2(DEADTIME_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD_COUNT - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEADTIME_CYCLES - 1);

  typedef enum logic [1:0] {ST_RUN, ST_DEAD, ST_WAIT} state_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          period_start_q, period_start_d;
  logic          boundary;
  logic          load;

  assign boundary = en && (cnt_q == CNT_LAST);
  // With the block disabled, active settings track the shadow continuously.
  assign load     = boundary || !en;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
    period_start_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DUTY_BITS-1:0] duty_sh_q, duty_sh_d;
      logic                 dir_sh_q, dir_sh_d;
      logic                 float_sh_q, float_sh_d;
      logic [TW-1:0]        thr_q, thr_d;
      logic [TW-1:0]        thr_new;
      logic                 act_float_q, act_float_d;
      logic                 float_n_q, float_n_d;
      logic                 dir_out_q, dir_out_d;
      logic                 tgt_dir_q, tgt_dir_d;
      logic [DW-1:0]        dead_q, dead_d;
      state_t               state_q, state_d;
      logic                 pwm_q, pwm_d;
      logic                 in_window;
      int                   duty_int;
`ifdef PWM_CENTER_ALIGNED_EN
      logic [TW-1:0]        start_q, start_d, end_q, end_d, start_new;
`endif

      always_comb begin
        duty_sh_d  = duty_sh_q;
        dir_sh_d   = dir_sh_q;
        float_sh_d = float_sh_q;
        if (update) begin
          duty_sh_d  = duty[gi*DUTY_BITS +: DUTY_BITS];
          dir_sh_d   = dir_in[gi];
          float_sh_d = float[gi];
        end

        duty_int = int'(duty_sh_q);
        if (duty_int > DUTY_MAX) begin
          duty_int = DUTY_MAX;
        end
        thr_new = TW'(duty_int * DUTY_STEP);

        thr_d       = thr_q;
        act_float_d = act_float_q;
        float_n_d   = float_n_q;
`ifdef PWM_CENTER_ALIGNED_EN
        start_new = TW'((PERIOD_COUNT - int'(thr_new)) / 2);
        start_d   = start_q;
        end_d     = end_q;
`endif
        if (load) begin
          thr_d       = thr_new;
          act_float_d = float_sh_q;
          float_n_d   = ~float_sh_q;
`ifdef PWM_CENTER_ALIGNED_EN
          start_d     = start_new;
          end_d       = start_new + thr_new;
`endif
        end

        state_d   = state_q;
        dead_d    = dead_q;
        dir_out_d = dir_out_q;
        tgt_dir_d = tgt_dir_q;
        if (!en) begin
          state_d   = ST_RUN;
          dir_out_d = dir_sh_q;
        end else begin
          case (state_q)
            ST_RUN, ST_WAIT: begin
              // The shadow dir is what active receives on this boundary.
              if (boundary) begin
                if (dir_sh_q != dir_out_q) begin
                  state_d   = ST_DEAD;
                  dead_d    = '0;
                  tgt_dir_d = dir_sh_q;
                end else begin
                  state_d = ST_RUN;
                end
              end
            end
            ST_DEAD: begin
              if (dead_q == DEAD_LAST) begin
                dir_out_d = tgt_dir_q;
                state_d   = ST_WAIT;
              end else begin
                dead_d = dead_q + 1'b1;
              end
            end
            default: state_d = ST_RUN;
          endcase
        end

`ifdef PWM_CENTER_ALIGNED_EN
        in_window = (TW'(cnt_q) >= start_q) && (TW'(cnt_q) < end_q);
`else
        in_window = TW'(cnt_q) < thr_q;
`endif
        pwm_d = en && !act_float_q && in_window &&
                (state_q == ST_RUN) && (state_d == ST_RUN);
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          duty_sh_q   <= '0;
          dir_sh_q    <= 1'b0;
          float_sh_q  <= 1'b0;
          thr_q       <= '0;
          act_float_q <= 1'b0;
          float_n_q   <= 1'b0;
          dir_out_q   <= 1'b0;
          tgt_dir_q   <= 1'b0;
          dead_q      <= '0;
          state_q     <= ST_RUN;
          pwm_q       <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
          start_q     <= '0;
          end_q       <= '0;
`endif
        end else begin
          duty_sh_q   <= duty_sh_d;
          dir_sh_q    <= dir_sh_d;
          float_sh_q  <= float_sh_d;
          thr_q       <= thr_d;
          act_float_q <= act_float_d;
          float_n_q   <= float_n_d;
          dir_out_q   <= dir_out_d;
          tgt_dir_q   <= tgt_dir_d;
          dead_q      <= dead_d;
          state_q     <= state_d;
          pwm_q       <= pwm_d;
`ifdef PWM_CENTER_ALIGNED_EN
          start_q     <= start_d;
          end_q       <= end_d;
`endif
        end
      end

      assign pwm[gi]     = pwm_q;
      assign dir_out[gi] = dir_out_q;
      assign float_n[gi] = float_n_q;
    end
  endgenerate

endmodule

// File: tb/tb_pwm_dir_multi.sv
// Bench for pwm_dir_multi: cycle-level reference model plus directed period-level checks
// and a randomized stimulus phase.
module tb_pwm_dir_multi;
  localparam int NUM_CH = 2;
  localparam int DB     = 7;
  localparam int P      = 600;
  localparam int DMAX   = 100;
  localparam int STEP   = 6;
  localparam int DT     = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, en, upd;
  logic [NUM_CH*DB-1:0]    duty_v;
  logic [NUM_CH-1:0]       dir_v, flt_v;
  wire  [NUM_CH-1:0]       pwm, dir_out, float_n;
  wire                     period_start;

  pwm_dir_multi #(
    .NUM_CH(NUM_CH), .CLK_FREQUENCY(60_000_000), .PWM_FREQUENCY(100_000),
    .DUTY_BITS(DB), .DUTY_MAX(DMAX), .DEADTIME_CYCLES(DT)
  ) dut (
    .clk(clk), .reset(rst), .en(en), .update(upd), .duty(duty_v),
    .dir_in(dir_v), .float(flt_v), .pwm(pwm), .dir_out(dir_out),
    .float_n(float_n), .period_start(period_start)
  );

  // Reference model: expected outputs after each edge.
  int                m_cnt;
  logic [NUM_CH-1:0] m_pwm, m_dir, m_fn, blank, pend, sh_dir, sh_flt, a_flt;
  logic              m_ps;
  int                sh_duty[NUM_CH];
  int                a_thr[NUM_CH];
  int                flip_left[NUM_CH];

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0, last_ps = 0, ps_gap = 0, widx = 0;
  int acc[NUM_CH], last_hi[NUM_CH], cur_first[NUM_CH], first_hi[NUM_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int thr_of(input int d);
    return ((d > DMAX) ? DMAX : d) * STEP;
  endfunction

  function automatic logic in_win(input int c, input int thr);
`ifdef PWM_CENTER_ALIGNED_EN
    int s;
    s = (P - thr) / 2;
    return (c >= s) && (c < s + thr);
`else
    return c < thr;
`endif
  endfunction

  task automatic model_step();
    logic bnd, rev;
    logic [NUM_CH-1:0] n_pwm;
    if (rst) begin
      m_cnt = 0; m_ps = 1'b0;
      m_pwm = '0; m_dir = '0; m_fn = '0; blank = '0; pend = '0;
      sh_dir = '0; sh_flt = '0; a_flt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        sh_duty[i] = 0; a_thr[i] = 0; flip_left[i] = 0;
      end
      return;
    end
    bnd = en && (m_cnt == P - 1);
    for (int i = 0; i < NUM_CH; i++) begin
      rev = sh_dir[i] != m_dir[i];
      n_pwm[i] = en && !a_flt[i] && !blank[i] && in_win(m_cnt, a_thr[i]) && !(bnd && rev);
      if (!en) begin
        blank[i] = 1'b0; flip_left[i] = 0; m_dir[i] = sh_dir[i];
      end else if (flip_left[i] > 0) begin
        flip_left[i]--;
        if (flip_left[i] == 0) m_dir[i] = pend[i];
      end else if (bnd) begin
        if (rev) begin
          blank[i] = 1'b1; flip_left[i] = DT; pend[i] = sh_dir[i];
        end else begin
          blank[i] = 1'b0;
        end
      end
      if (bnd || !en) begin
        a_thr[i] = thr_of(sh_duty[i]); a_flt[i] = sh_flt[i]; m_fn[i] = !sh_flt[i];
      end
      if (upd) begin
        sh_duty[i] = int'(duty_v[i*DB +: DB]); sh_dir[i] = dir_v[i]; sh_flt[i] = flt_v[i];
      end
    end
    m_pwm = n_pwm;
    m_ps  = bnd;
    m_cnt = (!en || m_cnt == P - 1) ? 0 : m_cnt + 1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("pwm", 32'(pwm), 32'(m_pwm));
    check("dir_out", 32'(dir_out), 32'(m_dir));
    check("float_n", 32'(float_n), 32'(m_fn));
    check("period_start", 32'(period_start), 32'(m_ps));
    if (period_start) begin
      ps_gap = cyc - last_ps; last_ps = cyc; widx = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        last_hi[i] = acc[i]; acc[i] = 0; first_hi[i] = cur_first[i]; cur_first[i] = -1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (pwm[i]) begin
        acc[i]++;
        if (cur_first[i] < 0) cur_first[i] = widx;
      end
    end
    widx++;
    cyc++;
  endtask

  task automatic set_ch(input int ch, input int d, input logic dr, input logic fl);
    duty_v[ch*DB +: DB] = DB'(d); dir_v[ch] = dr; flt_v[ch] = fl;
  endtask

  task automatic do_update();
    $display("[TB] update duty=%h dir=%b float=%b at cnt=%0d", duty_v, dir_v, flt_v, m_cnt);
    upd = 1'b1; tick(); upd = 1'b0;
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    do begin tick(); n++; end while (!period_start && n < 2 * P);
    check("wait_ps_bound", 32'(!period_start), 0);
  endtask

  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    while (m_cnt != v && n < 2 * P) begin tick(); n++; end
    check("wait_cnt_bound", 32'(m_cnt != v), 0);
  endtask

  initial begin
    int n, r, exp_first;
    for (int i = 0; i < NUM_CH; i++) begin
      acc[i] = 0; last_hi[i] = 0; cur_first[i] = -1; first_hi[i] = -1;
    end
    rst = 1'b1; en = 1'b0; upd = 1'b0; duty_v = '0; dir_v = '0; flt_v = '0;
    repeat (3) tick();
    check("rst_pwm", 32'(pwm), 0);
    check("rst_float_n", 32'(float_n), 0);
    check("rst_ps", 32'(period_start), 0);
    rst = 1'b0;

    // 1: duty 50 on ch0
    en = 1'b1;
    set_ch(0, 50, 1'b0, 1'b0);
    do_update();
    repeat (3) wait_ps();
    check("t1_hi", last_hi[0], 300);
    check("t1_gap", ps_gap, P);
    check("t1_float_n0", 32'(float_n[0]), 1);
`ifdef PWM_CENTER_ALIGNED_EN
    exp_first = 151;
`else
    exp_first = 1;
`endif
    check("t1_first_hi", first_hi[0], exp_first);

    // 2: ch1 duty 0, 100, 127 (clamp)
    set_ch(1, 0, 1'b0, 1'b0); do_update(); repeat (3) wait_ps();
    check("t2_duty0", last_hi[1], 0);
    set_ch(1, 100, 1'b0, 1'b0); do_update(); repeat (3) wait_ps();
    check("t2_duty100", last_hi[1], P);
    set_ch(1, 127, 1'b0, 1'b0); do_update(); repeat (3) wait_ps();
    check("t2_duty127", last_hi[1], P);
    check("t2_ch0", last_hi[0], 300);

    // 3: mid-period update and update on the boundary cycle
    wait_cnt(200);
    set_ch(0, 25, 1'b0, 1'b0); do_update();
    wait_ps(); check("t3_cur", last_hi[0], 300);
    wait_ps(); check("t3_next", last_hi[0], 150);
    wait_cnt(P - 1);
    set_ch(0, 50, 1'b0, 1'b0); do_update();
    check("t3_b0", last_hi[0], 150);
    wait_ps(); check("t3_b1", last_hi[0], 150);
    wait_ps(); check("t3_b2", last_hi[0], 300);

    // 4: ch1 reversal with dead-time
    set_ch(1, 50, 1'b1, 1'b0); do_update();
    wait_ps();
    n = 0;
    while (dir_out[1] == 1'b0 && n < 200) begin tick(); n++; end
    check("t4_dead_len", n, DT);
    wait_ps(); check("t4_blank", last_hi[1], 0); check("t4_ch0", last_hi[0], 300);
    wait_ps(); check("t4_run", last_hi[1], 300);

    // 5: float ch0, then reset in the middle of dead-time
    set_ch(0, 50, 1'b0, 1'b1); do_update();
    wait_ps(); check("t5_float_n0", 32'(float_n[0]), 0);
    wait_ps(); check("t5_float_pwm", last_hi[0], 0);
    set_ch(1, 50, 1'b0, 1'b0); do_update();
    wait_ps();
    repeat (10) tick();
    rst = 1'b1; tick();
    check("t5_rst_pwm", 32'(pwm), 0);
    check("t5_rst_dir", 32'(dir_out), 0);
    check("t5_rst_float_n", 32'(float_n), 0);
    check("t5_rst_ps", 32'(period_start), 0);
    rst = 1'b0;

    // 6: en fall while pwm high, counter held at 0
    set_ch(0, 50, 1'b0, 1'b0); do_update();
    repeat (2) wait_ps();
    wait_cnt(100);
    check("t6_pre_high", 32'(pwm[0]), 1);
    en = 1'b0; tick();
    check("t6_pwm_off", 32'(pwm), 0);
    repeat (5) tick();
    en = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!period_start && n < 700);
    check("t6_cnt_held", n, P);

    // Randomized phase against the model
    $display("[TB] random phase start");
    for (int k = 0; k < 8000; k++) begin
      r = int'($urandom_range(0, 9999));
      rst = (r < 3);
      if (!en) en = (r < 500);
      else if (r < 15) en = 1'b0;
      upd = ($urandom_range(0, 99) < 2);
      if (upd) begin
        for (int i = 0; i < NUM_CH; i++) begin
          duty_v[i*DB +: DB] = DB'($urandom_range(0, 127));
          if ($urandom_range(0, 3) == 0) dir_v[i] = ~dir_v[i];
          flt_v[i] = ($urandom_range(0, 7) == 0);
        end
      end
      tick();
    end
    rst = 1'b0; upd = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
